// File: rtl/seq_divider.sv
// seq_divider: sequential restoring unsigned divider with a start/busy/done handshake
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   start_i                    request, accepted only while idle
//   dividend_i, divisor_i      operands, captured on the accepting edge
//   busy_o                     high while iterations are running
//   done_o                     one-cycle pulse when results become valid
//   quotient_o, remainder_o    results, held until the next accepted start
//   div_by_zero_o              flags a zero divisor, held with the results
module seq_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] quotient_o,
   output logic [DATA_WIDTH-1:0] remainder_o,
   output logic                  div_by_zero_o
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
   state_t state_q, state_d;
   logic [W-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d, dvd_q, dvd_d, quo_q, quo_d, rem_q, rem_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic dbz_q, dbz_d, done_q, done_d;
   logic [W:0] shifted, trial;
   // The stored remainder always stays below the divisor, so its extra MSB
   // only exists in the shifted/trial path where the doubling can overflow W bits.
   assign shifted = {r_q, q_q[W-1]};
   assign trial   = shifted + ~{1'b0, dvs_q} + 1'b1;
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dvs_d   = dvs_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (start_i) begin
            dvd_d   = dividend_i;
            dvs_d   = divisor_i;
            r_d     = '0;
            q_d     = dividend_i;
            cnt_d   = CW'(W - 1);
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = (divisor_i == '0) ? FINISH : CALC;
         end
         CALC: begin
            // Trial MSB set means the subtraction borrowed: restore the shifted value.
            r_d     = trial[W] ? shifted[W-1:0] : trial[W-1:0];
            q_d     = {q_q[W-2:0], ~trial[W]};
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == '0) ? FINISH : CALC;
         end
         FINISH: begin
            done_d  = 1'b1;
            dbz_d   = (dvs_q == '0);
            quo_d   = (dvs_q == '0) ? '1 : q_q;
            rem_d   = (dvs_q == '0) ? dvd_q : r_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         dvs_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dvs_q   <= dvs_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end
   assign busy_o        = (state_q == CALC);
   assign done_o        = done_q;
   assign quotient_o    = quo_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;
endmodule
